// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - fetch-side shared-bus interface used by if_stage
//
// Groups the bus master handshake of the fetch stage. Every strobe with a
// trailing underscore is active-low.
//   bus_req_     master->slave  bus request
//   bus_grnt_    slave->master  bus grant
//   bus_as_      master->slave  address strobe
//   bus_addr     master->slave  30-bit word address, latched at grant
//   bus_rw       master->slave  1 = read (the fetch stage only reads)
//   bus_wr_data  master->slave  write data, held at zero
//   bus_rd_data  slave->master  read data
//   bus_rdy_     slave->master  read data valid
interface if_stage_if;
    logic        bus_req_;
    logic        bus_grnt_;
    logic        bus_as_;
    logic [29:0] bus_addr;
    logic        bus_rw;
    logic [31:0] bus_wr_data;
    logic [31:0] bus_rd_data;
    logic        bus_rdy_;

    modport master (
        output bus_req_, bus_as_, bus_addr, bus_rw, bus_wr_data,
        input  bus_grnt_, bus_rd_data, bus_rdy_
    );

    modport slave (
        input  bus_req_, bus_as_, bus_addr, bus_rw, bus_wr_data,
        output bus_grnt_, bus_rd_data, bus_rdy_
    );
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with IF/ID pipeline register
//
// Fetches one 32-bit word per instruction from the shared bus (or, when the
// IF_SPM_PATH_EN macro is defined, from the scratch-pad for PCs whose
// addr[29:27] equals SPM_SEL) and presents it to decode.
// Ports:
//   clk, reset     clock; asynchronous active-low reset
//   stall, flush   pipeline control; flush redirects fetch to new_pc
//   br_taken       branch resolved taken, target br_addr
//   busy           a bus fetch is outstanding this cycle
//   if_pc/if_insn  IF/ID register: next PC and fetched instruction
//   if_en          IF/ID entry valid
//   bus            if_stage_if master modport (req/grant/strobe/ready)
//   spm_addr, spm_as_, spm_rd_data  scratch-pad port (IF_SPM_PATH_EN only)
module if_stage #(
    parameter logic [29:0] RESET_VECTOR = 30'h0,
    parameter logic [2:0]  SPM_SEL      = 3'h1,
    parameter logic [31:0] NOP_INSN     = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [29:0] new_pc,
    input  logic        br_taken,
    input  logic [29:0] br_addr,
    output logic        busy,
    output logic [29:0] if_pc,
    output logic [31:0] if_insn,
    output logic        if_en,
    if_stage_if.master  bus
`ifdef IF_SPM_PATH_EN
    ,
    output logic [29:0] spm_addr,
    output logic        spm_as_,
    input  logic [31:0] spm_rd_data
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_STALL  = 2'd3;

    logic [1:0]  state;
    logic        discard;
    logic [31:0] rd_buf;
    logic [31:0] fetched;
    logic        spm_hit;
    logic        drop;

`ifdef IF_SPM_PATH_EN
    // The scratch-pad answers in the same cycle, so a hit never leaves IDLE.
    assign spm_hit  = (state == ST_IDLE) && (if_pc[29:27] == SPM_SEL);
    assign spm_addr = if_pc;
    assign spm_as_  = ~spm_hit;
`else
    logic unused_spm_sel;
    assign spm_hit        = 1'b0;
    assign unused_spm_sel = ^SPM_SEL;
`endif

    assign bus.bus_rw      = 1'b1;
    assign bus.bus_wr_data = 32'h0;

    // A flushed access still runs to completion on the bus; its data must not
    // reach IF/ID even though busy drops on the ready cycle.
    assign drop = (state == ST_ACCESS) && discard;

    always_comb begin
        busy    = 1'b0;
        fetched = rd_buf;
        case (state)
            ST_IDLE:   busy = reset & ~flush & ~spm_hit;
            ST_REQ:    busy = 1'b1;
            ST_ACCESS: begin
                busy    = bus.bus_rdy_;
                fetched = bus.bus_rd_data;
            end
            default:   fetched = rd_buf;
        endcase
`ifdef IF_SPM_PATH_EN
        if (spm_hit) begin
            fetched = spm_rd_data;
        end
`endif
    end

    // Bus master FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            discard      <= 1'b0;
            rd_buf       <= NOP_INSN;
            bus.bus_req_ <= 1'b1;
            bus.bus_as_  <= 1'b1;
            bus.bus_addr <= 30'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!flush && !spm_hit) begin
                        bus.bus_req_ <= 1'b0;
                        state        <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (flush) begin
                        bus.bus_req_ <= 1'b1;
                        state        <= ST_IDLE;
                    end else if (!bus.bus_grnt_) begin
                        bus.bus_as_  <= 1'b0;
                        bus.bus_addr <= if_pc;
                        state        <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!bus.bus_rdy_) begin
                        bus.bus_req_ <= 1'b1;
                        bus.bus_as_  <= 1'b1;
                        discard      <= 1'b0;
                        rd_buf       <= bus.bus_rd_data;
                        // Data parked in rd_buf is only useful if it was kept.
                        state        <= (discard || flush || !stall) ? ST_IDLE : ST_STALL;
                    end else if (flush) begin
                        discard <= 1'b1;
                    end
                end
                default: begin
                    if (flush || !stall) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // IF/ID pipeline register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_pc   <= RESET_VECTOR;
            if_insn <= NOP_INSN;
            if_en   <= 1'b0;
        end else if (flush) begin
            if_pc   <= new_pc;
            if_insn <= NOP_INSN;
            if_en   <= 1'b0;
        end else if (stall || busy || drop) begin
            if_pc   <= if_pc;
        end else if (br_taken) begin
            if_pc   <= br_addr;
            if_insn <= fetched;
            if_en   <= 1'b1;
        end else begin
            if_pc   <= if_pc + 30'd1;
            if_insn <= fetched;
            if_en   <= 1'b1;
        end
    end

endmodule
